// File: rtl/ysyx_22051013_ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM state encoding, width constants and small op-decode helpers.
package ysyx_22051013_ex_mdu_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  // mdu op encodings as carried by the ID/EX register
  localparam logic [3:0] ysyx_22051013_MDU_NONE   = 4'd0;
  localparam logic [3:0] ysyx_22051013_MDU_MUL    = 4'd1;
  localparam logic [3:0] ysyx_22051013_MDU_MULH   = 4'd2;
  localparam logic [3:0] ysyx_22051013_MDU_MULHSU = 4'd3;
  localparam logic [3:0] ysyx_22051013_MDU_MULHU  = 4'd4;
  localparam logic [3:0] ysyx_22051013_MDU_MULW   = 4'd5;
  localparam logic [3:0] ysyx_22051013_MDU_DIV    = 4'd6;
  localparam logic [3:0] ysyx_22051013_MDU_DIVU   = 4'd7;
  localparam logic [3:0] ysyx_22051013_MDU_REM    = 4'd8;
  localparam logic [3:0] ysyx_22051013_MDU_REMU   = 4'd9;
  localparam logic [3:0] ysyx_22051013_MDU_DIVW   = 4'd10;
  localparam logic [3:0] ysyx_22051013_MDU_DIVUW  = 4'd11;
  localparam logic [3:0] ysyx_22051013_MDU_REMW   = 4'd12;
  localparam logic [3:0] ysyx_22051013_MDU_REMUW  = 4'd13;

  // FSM state encodings
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // 64-bit constants
  localparam logic [XLEN-1:0] MDU_ZERO64 = 64'h0000_0000_0000_0000;
  localparam logic [XLEN-1:0] MDU_ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [XLEN-1:0] MDU_MIN64  = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] MDU_MIN32X = 64'hFFFF_FFFF_8000_0000;

  // iteration counts minus one (counter runs down to zero)
  localparam logic [CNT_W-1:0] MDU_CNT_64 = 7'd63;
  localparam logic [CNT_W-1:0] MDU_CNT_32 = 7'd31;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op != ysyx_22051013_MDU_NONE) && (op <= ysyx_22051013_MDU_REMUW);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    case (op)
      ysyx_22051013_MDU_MUL, ysyx_22051013_MDU_MULH, ysyx_22051013_MDU_MULHSU,
      ysyx_22051013_MDU_MULHU, ysyx_22051013_MDU_MULW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    case (op)
      ysyx_22051013_MDU_DIV, ysyx_22051013_MDU_DIVU, ysyx_22051013_MDU_REM,
      ysyx_22051013_MDU_REMU, ysyx_22051013_MDU_DIVW, ysyx_22051013_MDU_DIVUW,
      ysyx_22051013_MDU_REMW, ysyx_22051013_MDU_REMUW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_mulh_op(input logic [3:0] op);
    case (op)
      ysyx_22051013_MDU_MULH, ysyx_22051013_MDU_MULHSU,
      ysyx_22051013_MDU_MULHU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ops whose result is the quotient (others in the divide class return the remainder)
  function automatic logic is_quot_op(input logic [3:0] op);
    case (op)
      ysyx_22051013_MDU_DIV, ysyx_22051013_MDU_DIVU, ysyx_22051013_MDU_DIVW,
      ysyx_22051013_MDU_DIVUW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_w_op(input logic [3:0] op);
    case (op)
      ysyx_22051013_MDU_MULW, ysyx_22051013_MDU_DIVW, ysyx_22051013_MDU_DIVUW,
      ysyx_22051013_MDU_REMW, ysyx_22051013_MDU_REMUW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // rs1 is interpreted as signed
  function automatic logic op_signed1(input logic [3:0] op);
    case (op)
      ysyx_22051013_MDU_MUL, ysyx_22051013_MDU_MULH, ysyx_22051013_MDU_MULHSU,
      ysyx_22051013_MDU_MULW, ysyx_22051013_MDU_DIV, ysyx_22051013_MDU_REM,
      ysyx_22051013_MDU_DIVW, ysyx_22051013_MDU_REMW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // rs2 is interpreted as signed
  function automatic logic op_signed2(input logic [3:0] op);
    case (op)
      ysyx_22051013_MDU_MUL, ysyx_22051013_MDU_MULH, ysyx_22051013_MDU_MULW,
      ysyx_22051013_MDU_DIV, ysyx_22051013_MDU_REM, ysyx_22051013_MDU_DIVW,
      ysyx_22051013_MDU_REMW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22051013_mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module ysyx_22051013_mdu_div_step
  import ysyx_22051013_ex_mdu_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0]   shifted_s;
  logic [XLEN-1:0] diff_s;

  // trial subtraction; the true difference always fits in XLEN bits when it is kept
  always_comb begin
    shifted_s = {rem_in, dvd_bit};
    diff_s    = shifted_s[XLEN-1:0] - divisor;
    q_bit     = (shifted_s >= {1'b0, divisor});
    if (q_bit) begin
      rem_out = diff_s;
    end else begin
      rem_out = shifted_s[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ysyx_22051013_ex_mdu.sv
// Iterative RV64M multiply/divide unit in the EX stage.
// Multiplies with radix-2 shift-add, divides with restoring division, one bit
// per cycle, on unsigned magnitudes with the sign fixed up at the end.
// Holds ID/EX through mdu_busy and hands the result on via valid/ready.
// Optional macro YSYX_22051013_MDU_ZERO_SKIP_EN: zero-operand multiplies and
// zero-dividend divides finish one cycle after start.
module ysyx_22051013_ex_mdu
  import ysyx_22051013_ex_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [3:0]      ex_mdu_op,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_op2,
  input  logic            ex_flush,
  input  logic            out_ready,
  output logic            mdu_busy,
  output logic            mdu_valid,
  output logic [XLEN-1:0] mdu_result
);

  // architectural state
  mdu_state_e        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [3:0]        op_r, op_s;
  logic [XLEN-1:0]   mcand_r, mcand_s;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_r, acc_s;         // product, or {remainder, dividend/quotient}
  logic              neg_q_r, neg_q_s;     // product / quotient must be negated
  logic              neg_r_r, neg_r_s;     // remainder must be negated
  logic [XLEN-1:0]   result_r, result_s;
  logic              valid_r, valid_s;

  // start-cycle operand decode
  logic              start_s;
  logic              in_w_s;
  logic [XLEN-1:0]   ext1_s, ext2_s;
  logic              neg1_s, neg2_s;
  logic [XLEN-1:0]   mag1_s, mag2_s;
  logic              div0_s, ovf_s;
  logic [XLEN-1:0]   spec_sel_s, spec_res_s;
  logic              zskip_mul_s, zskip_div_s;

  // iteration datapath
  logic              run_w_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_next_s, mul_raw_s, mul_fix_s;
  logic [XLEN-1:0]   mul_res_s;
  logic [XLEN-1:0]   div_rem_s;
  logic              div_qbit_s;
  logic [2*XLEN-1:0] div_next_s;
  logic [XLEN-1:0]   quot_raw_s, quot_fix_s, rem_fix_s, div_sel_s, div_res_s;

  // decode the op sitting in ID/EX: extend, take magnitudes, spot special divides
  always_comb begin
    start_s = ex_valid & is_mdu_op(ex_mdu_op) & (state_r == MDU_IDLE) & ~ex_flush;
    in_w_s  = is_w_op(ex_mdu_op);
    if (in_w_s) begin
      ext1_s = op_signed1(ex_mdu_op) ? sext32(ex_op1[31:0]) : {32'h0000_0000, ex_op1[31:0]};
      ext2_s = op_signed2(ex_mdu_op) ? sext32(ex_op2[31:0]) : {32'h0000_0000, ex_op2[31:0]};
    end else begin
      ext1_s = ex_op1;
      ext2_s = ex_op2;
    end
    neg1_s = op_signed1(ex_mdu_op) & ext1_s[XLEN-1];
    neg2_s = op_signed2(ex_mdu_op) & ext2_s[XLEN-1];
    mag1_s = neg1_s ? (MDU_ZERO64 - ext1_s) : ext1_s;
    mag2_s = neg2_s ? (MDU_ZERO64 - ext2_s) : ext2_s;
    div0_s = (ext2_s == MDU_ZERO64);
    ovf_s  = op_signed1(ex_mdu_op) & is_div_op(ex_mdu_op) & (ext2_s == MDU_ONES64) &
             (ext1_s == (in_w_s ? MDU_MIN32X : MDU_MIN64));
    if (div0_s) begin
      spec_sel_s = is_quot_op(ex_mdu_op) ? MDU_ONES64 : ext1_s;
    end else begin
      spec_sel_s = is_quot_op(ex_mdu_op) ? ext1_s : MDU_ZERO64;
    end
    spec_res_s = in_w_s ? sext32(spec_sel_s[31:0]) : spec_sel_s;
  end

`ifdef YSYX_22051013_MDU_ZERO_SKIP_EN
  assign zskip_mul_s = (ext1_s == MDU_ZERO64) | (ext2_s == MDU_ZERO64);
  assign zskip_div_s = (ext1_s == MDU_ZERO64) & ~div0_s;
`else
  assign zskip_mul_s = 1'b0;
  assign zskip_div_s = 1'b0;
`endif

  ysyx_22051013_mdu_div_step u_div_step (
    .rem_in  (acc_r[2*XLEN-1:XLEN]),
    .dvd_bit (acc_r[XLEN-1]),
    .divisor (mcand_r),
    .rem_out (div_rem_s),
    .q_bit   (div_qbit_s)
  );

  // one multiply and one divide iteration plus their final sign fix-ups
  always_comb begin
    run_w_s    = is_w_op(op_r);
    // shift-add: add multiplicand into the high half when the multiplier LSB is set
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                 (acc_r[0] ? {1'b0, mcand_r} : {1'b0, MDU_ZERO64});
    mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
    // a W multiply only runs 32 steps, so its product still sits 32 bits up
    mul_raw_s  = run_w_s ? (mul_next_s >> 32) : mul_next_s;
    mul_fix_s  = neg_q_r ? (~mul_raw_s + 128'd1) : mul_raw_s;
    if (is_mulh_op(op_r)) begin
      mul_res_s = mul_fix_s[2*XLEN-1:XLEN];
    end else if (run_w_s) begin
      mul_res_s = sext32(mul_fix_s[31:0]);
    end else begin
      mul_res_s = mul_fix_s[XLEN-1:0];
    end

    div_next_s = {div_rem_s, acc_r[XLEN-2:0], div_qbit_s};
    quot_raw_s = run_w_s ? {32'h0000_0000, div_next_s[31:0]} : div_next_s[XLEN-1:0];
    quot_fix_s = neg_q_r ? (MDU_ZERO64 - quot_raw_s) : quot_raw_s;
    rem_fix_s  = neg_r_r ? (MDU_ZERO64 - div_rem_s) : div_rem_s;
    div_sel_s  = is_quot_op(op_r) ? quot_fix_s : rem_fix_s;
    div_res_s  = run_w_s ? sext32(div_sel_s[31:0]) : div_sel_s;
  end

  // FSM next-state and datapath next values
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    op_s     = op_r;
    mcand_s  = mcand_r;
    acc_s    = acc_r;
    neg_q_s  = neg_q_r;
    neg_r_s  = neg_r_r;
    result_s = result_r;
    valid_s  = 1'b0;
    if (ex_flush) begin
      state_s = MDU_IDLE;
    end else begin
      case (state_r)
        MDU_IDLE: begin
          if (start_s) begin
            op_s    = ex_mdu_op;
            cnt_s   = in_w_s ? MDU_CNT_32 : MDU_CNT_64;
            neg_q_s = neg1_s ^ neg2_s;
            neg_r_s = neg1_s;
            if (is_mul_op(ex_mdu_op)) begin
              mcand_s = mag1_s;
              acc_s   = {MDU_ZERO64, mag2_s};
              if (zskip_mul_s) begin
                state_s  = MDU_DONE;
                result_s = MDU_ZERO64;
                valid_s  = 1'b1;
              end else begin
                state_s = MDU_MUL;
              end
            end else begin
              mcand_s = mag2_s;
              // W dividends are left-justified so the MSB is shifted in first
              acc_s   = in_w_s ? {MDU_ZERO64, mag1_s[31:0], 32'h0000_0000}
                               : {MDU_ZERO64, mag1_s};
              if (div0_s || ovf_s) begin
                state_s  = MDU_DONE;
                result_s = spec_res_s;
                valid_s  = 1'b1;
              end else if (zskip_div_s) begin
                state_s  = MDU_DONE;
                result_s = MDU_ZERO64;
                valid_s  = 1'b1;
              end else begin
                state_s = MDU_DIV;
              end
            end
          end else begin
            state_s = MDU_IDLE;
          end
        end
        MDU_MUL: begin
          acc_s = mul_next_s;
          if (cnt_r == 7'd0) begin
            state_s  = MDU_DONE;
            result_s = mul_res_s;
            valid_s  = 1'b1;
          end else begin
            cnt_s   = cnt_r - 7'd1;
            state_s = MDU_MUL;
          end
        end
        MDU_DIV: begin
          acc_s = div_next_s;
          if (cnt_r == 7'd0) begin
            state_s  = MDU_DONE;
            result_s = div_res_s;
            valid_s  = 1'b1;
          end else begin
            cnt_s   = cnt_r - 7'd1;
            state_s = MDU_DIV;
          end
        end
        MDU_DONE: begin
          if (out_ready) begin
            state_s = MDU_IDLE;
          end else begin
            state_s = MDU_DONE;
            valid_s = 1'b1;
          end
        end
        default: begin
          state_s = MDU_IDLE;
        end
      endcase
    end
  end

  // state and datapath registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= MDU_IDLE;
      cnt_r    <= 7'd0;
      op_r     <= 4'd0;
      mcand_r  <= MDU_ZERO64;
      acc_r    <= {MDU_ZERO64, MDU_ZERO64};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= MDU_ZERO64;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      op_r     <= op_s;
      mcand_r  <= mcand_s;
      acc_r    <= acc_s;
      neg_q_r  <= neg_q_s;
      neg_r_r  <= neg_r_s;
      result_r <= result_s;
      valid_r  <= valid_s;
    end
  end

  // hold drops in the acceptance cycle so ID/EX advances exactly once
  assign mdu_busy   = start_s | (state_r == MDU_MUL) | (state_r == MDU_DIV) |
                      ((state_r == MDU_DONE) & ~out_ready);
  assign mdu_valid  = valid_r;
  assign mdu_result = result_r;

endmodule

// File: tb/tb_ysyx_22051013_ex_mdu.sv
// Scoreboard bench for ysyx_22051013_ex_mdu: stimulus pushes expected results
// and first-valid cycles; a negedge monitor checks them as the DUT presents them.
module tb_ysyx_22051013_ex_mdu;

  localparam logic [3:0] OP_MUL = 4'd1, OP_MULH = 4'd2, OP_MULHSU = 4'd3, OP_MULHU = 4'd4;
  localparam logic [3:0] OP_MULW = 4'd5, OP_DIV = 4'd6, OP_DIVU = 4'd7, OP_REM = 4'd8;
  localparam logic [3:0] OP_REMU = 4'd9, OP_DIVW = 4'd10, OP_DIVUW = 4'd11;
  localparam logic [3:0] OP_REMW = 4'd12, OP_REMUW = 4'd13;

`ifdef YSYX_22051013_MDU_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 65;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_flush, out_ready;
  logic [3:0]  ex_mdu_op;
  logic [63:0] ex_op1, ex_op2;
  logic        mdu_busy, mdu_valid;
  logic [63:0] mdu_result;

  typedef struct {
    logic [63:0] res;
    int          due;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   op_id = 0;
  logic valid_q = 1'b0;

  ysyx_22051013_ex_mdu dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_mdu_op  (ex_mdu_op),
    .ex_op1     (ex_op1),
    .ex_op2     (ex_op2),
    .ex_flush   (ex_flush),
    .out_ready  (out_ready),
    .mdu_busy   (mdu_busy),
    .mdu_valid  (mdu_valid),
    .mdu_result (mdu_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // monitor: first-valid cycle and accepted result against the scoreboard head
  always @(negedge clk) begin
    if (mdu_valid && !valid_q) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid result %h appeared with nothing expected (cycle %0d)", mdu_result, cyc);
      end else if (cyc != sb[0].due) begin
        errors++;
        $display("FAIL latency op %0d valid at cycle %0d, required %0d", sb[0].id, cyc, sb[0].due);
      end
    end
    if (mdu_valid && out_ready && sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (mdu_result !== mon_e.res) begin
        errors++;
        $display("FAIL result op %0d got %h required %h", mon_e.id, mdu_result, mon_e.res);
      end
    end
    valid_q = mdu_valid;
  end

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  // issue one op with out_ready high, hold it in EX while busy, then retire it
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] want, input int lat);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    ex_valid  = 1'b1;
    ex_mdu_op = op;
    ex_op1    = a;
    ex_op2    = b;
    op_id++;
    e.res = want;
    e.due = cyc + lat;
    e.id  = op_id;
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (mdu_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL busy_len op %0d busy for %0d cycles, required %0d", op_id, n, lat);
    end
    @(posedge clk); #1;
    ex_valid  = 1'b0;
    ex_mdu_op = 4'd0;
    @(negedge clk);
    check64("idle_after_op", {62'd0, mdu_busy, mdu_valid}, 64'd0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL no_result op %0d still pending (%0d entries)", op_id, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    int   n;
    exp_t e;
    rst = 1'b1; ex_valid = 1'b0; ex_flush = 1'b0; out_ready = 1'b1;
    ex_mdu_op = 4'd0; ex_op1 = 64'd0; ex_op2 = 64'd0;
    #1;
    check64("reset_busy", {63'd0, mdu_busy}, 64'd0);
    check64("reset_valid", {63'd0, mdu_valid}, 64'd0);
    check64("reset_result", mdu_result, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // main function, 64-bit and W, plus the single-cycle special cases
    run_op(OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op(OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op(OP_MULH,   64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op(OP_MULW,   64'hFFFF_FFFF_0000_0003, 64'h0000_0000_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 33);
    run_op(OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op(OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op(OP_REM,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    run_op(OP_DIVU,   64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 65);
    run_op(OP_DIVW,   64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op(OP_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    run_op(OP_REMW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1);
    run_op(OP_DIVU,   64'h0000_0000_0000_1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op(OP_REMU,   64'd5, 64'd0, 64'd5, 1);
    run_op(OP_REMW,   64'h0000_0001_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);
    run_op(OP_DIVUW,  64'd100, 64'd7, 64'd14, 33);
    run_op(OP_REMUW,  64'd100, 64'd7, 64'd2, 33);
    run_op(OP_MUL,    64'd0, 64'd5, 64'd0, ZLAT);

    // unused op codes do nothing
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mdu_op = 4'd14; ex_op1 = 64'd3; ex_op2 = 64'd4;
    @(negedge clk);
    check64("op14_busy", {63'd0, mdu_busy}, 64'd0);
    @(posedge clk); #1;
    ex_mdu_op = 4'd0;
    @(negedge clk);
    check64("op0_busy", {63'd0, mdu_busy}, 64'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    repeat (3) @(negedge clk);

    // backpressure: result held stable while out_ready is low
    @(posedge clk); #1;
    out_ready = 1'b0;
    ex_valid = 1'b1; ex_mdu_op = OP_MULHU;
    ex_op1 = 64'h0000_0001_0000_0000; ex_op2 = 64'h0000_0001_0000_0000;
    op_id++;
    e.res = 64'd1; e.due = cyc + 65; e.id = op_id;
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (!mdu_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check64("bp_valid", {63'd0, mdu_valid}, 64'd1);
      check64("bp_result", mdu_result, 64'd1);
      check64("bp_busy", {63'd0, mdu_busy}, 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check64("bp_accept_busy", {63'd0, mdu_busy}, 64'd0);
    check64("bp_accept_valid", {63'd0, mdu_valid}, 64'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mdu_op = 4'd0;
    @(negedge clk);
    check64("bp_idle", {62'd0, mdu_busy, mdu_valid}, 64'd0);

    // flush ten cycles into a divide: nothing is ever produced
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mdu_op = OP_DIV; ex_op1 = 64'd1000; ex_op2 = 64'd7;
    repeat (10) begin
      @(posedge clk); #1;
    end
    ex_flush = 1'b1; ex_valid = 1'b0; ex_mdu_op = 4'd0;
    @(posedge clk); #1;
    ex_flush = 1'b0;
    @(negedge clk);
    check64("flush_idle", {62'd0, mdu_busy, mdu_valid}, 64'd0);
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (mdu_valid) saw = 1'b1;
    end
    check64("flush_no_valid", {63'd0, saw}, 64'd0);

    // asynchronous reset in the middle of a multiply
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mdu_op = OP_MUL; ex_op1 = 64'h55; ex_op2 = 64'h77;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1; ex_valid = 1'b0; ex_mdu_op = 4'd0;
    #1;
    check64("midrst_busy", {63'd0, mdu_busy}, 64'd0);
    check64("midrst_valid", {63'd0, mdu_valid}, 64'd0);
    check64("midrst_result", mdu_result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(OP_MUL, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_0100, 64'h0000_0000_0012_3400, 65);

    repeat (3) @(negedge clk);
    check64("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
